// File: rtl/apb_sin_pkg.sv
// Shared types and constants for the sin-lookup sweep master and its APB transfer engine.
package apb_sin_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_WR_SETUP,
    ST_WR_ACCESS,
    ST_SETTLE,
    ST_RD_SETUP,
    ST_RD_ACCESS,
    ST_PUSH,
    ST_FIN,
    ST_ABORT
  } sweep_state_t;

  localparam logic [31:0] CTRL_ADDR_DEF   = 32'h0000_0000;
  localparam logic [31:0] OUT_ADDR_DEF    = 32'h0000_0004;
  localparam int          SETTLE_CYC_DEF  = 1;
  localparam int          TIMEOUT_CYC_DEF = 16;

  // Raw output codes of the sin slave; the master passes them through untouched.
  localparam logic [31:0] SIN_ZERO = 32'h0000_0000;
  localparam logic [31:0] SIN_POS1 = 32'h0000_0001;
  localparam logic [31:0] SIN_NEG1 = 32'hFFFF_FFFE;
  localparam logic [31:0] SIN_R2   = 32'h3F35_04F3;
  localparam logic [31:0] SIN_NR2  = 32'hC0CA_FB0C;

endpackage

// File: rtl/apb_master_xfer.sv
// Single APB transfer engine: SETUP while i_req is first seen, ACCESS until PREADY or timeout.
// The caller holds i_req high across SETUP and ACCESS and drops it the cycle after ack/timeout.
module apb_master_xfer #(
  parameter int TIMEOUT_CYC = 16
) (
  input  logic        PCLK,
  input  logic        PRESET,
  input  logic        i_req,
  input  logic        i_wr,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_prdata,
  input  logic        i_pready,
  output logic        o_psel,
  output logic        o_penable,
  output logic        o_pwrite,
  output logic [31:0] o_paddr,
  output logic [31:0] o_pwdata,
  output logic        o_ack,
  output logic        o_timeout,
  output logic [31:0] o_rdata
);

  localparam logic [15:0] TMO_LOAD = 16'(TIMEOUT_CYC - 1);

  logic        r_access;
  logic [15:0] r_tmo;
  logic [31:0] r_rdata;

  assign o_ack     = r_access & i_pready;
  // Down-counter hits zero on the TIMEOUT_CYC-th ACCESS cycle.
  assign o_timeout = r_access & ~i_pready & (r_tmo == 16'd0);

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      r_access <= 1'b0;
      r_tmo    <= 16'd0;
      r_rdata  <= 32'd0;
    end else begin
      r_access <= i_req & ~o_ack & ~o_timeout;
      if (i_req && !r_access)
        r_tmo <= TMO_LOAD;
      else if (r_access && r_tmo != 16'd0)
        r_tmo <= r_tmo - 16'd1;
      if (o_ack && !i_wr)
        r_rdata <= i_prdata;
    end
  end

  assign o_psel    = i_req;
  assign o_penable = r_access;
  assign o_pwrite  = i_req & i_wr;
  assign o_paddr   = i_req ? i_addr : 32'd0;
  assign o_pwdata  = (i_req && i_wr) ? i_wdata : 32'd0;
  assign o_rdata   = r_rdata;

endmodule

// File: rtl/apb_sin_sweep_master.sv
// Sweeps x over [x_start, x_start+x_count) against the sin slave and streams (x, sin code) results.
// state     | meaning
// IDLE      | waiting for start
// WR_SETUP  | APB setup, write x to control reg
// WR_ACCESS | APB access for the write
// SETTLE    | bus idle while slave output settles
// RD_SETUP  | APB setup, read output reg
// RD_ACCESS | APB access for the read
// PUSH      | result valid, waiting for res_ready
// FIN       | done pulse, sweep complete
// ABORT     | done pulse after APB timeout
module apb_sin_sweep_master
  import apb_sin_pkg::*;
#(
  parameter logic [31:0] CTRL_ADDR   = CTRL_ADDR_DEF,
  parameter logic [31:0] OUT_ADDR    = OUT_ADDR_DEF,
  parameter int          SETTLE_CYC  = SETTLE_CYC_DEF,
  parameter int          TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic        PCLK,
  input  logic        PRESET,
  input  logic        start,
  input  logic [31:0] x_start,
  input  logic [15:0] x_count,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic        PSEL,
  output logic        PENABLE,
  output logic        PWRITE,
  output logic [31:0] PADDR,
  output logic [31:0] PWDATA,
  input  logic [31:0] PRDATA,
  input  logic        PREADY,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [31:0] res_x,
  output logic [31:0] res_data
);

  sweep_state_t r_state, w_next;
  logic [31:0]  r_x;
  logic [15:0]  r_remaining;
  logic [7:0]   r_settle;
  logic         r_err;

  logic         w_req, w_wr, w_ack, w_timeout;
  logic [31:0]  w_rdata;

  assign w_wr  = (r_state == ST_WR_SETUP) || (r_state == ST_WR_ACCESS);
  assign w_req = w_wr || (r_state == ST_RD_SETUP) || (r_state == ST_RD_ACCESS);

  apb_master_xfer #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_xfer (
    .PCLK      (PCLK),
    .PRESET    (PRESET),
    .i_req     (w_req),
    .i_wr      (w_wr),
    .i_addr    (w_wr ? CTRL_ADDR : OUT_ADDR),
    .i_wdata   (r_x),
    .i_prdata  (PRDATA),
    .i_pready  (PREADY),
    .o_psel    (PSEL),
    .o_penable (PENABLE),
    .o_pwrite  (PWRITE),
    .o_paddr   (PADDR),
    .o_pwdata  (PWDATA),
    .o_ack     (w_ack),
    .o_timeout (w_timeout),
    .o_rdata   (w_rdata)
  );

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:      if (start) w_next = (x_count == 16'd0) ? ST_FIN : ST_WR_SETUP;
      ST_WR_SETUP:  w_next = ST_WR_ACCESS;
      ST_WR_ACCESS: if (w_ack) w_next = ST_SETTLE;
                    else if (w_timeout) w_next = ST_ABORT;
      ST_SETTLE:    if (r_settle == 8'd0) w_next = ST_RD_SETUP;
      ST_RD_SETUP:  w_next = ST_RD_ACCESS;
      ST_RD_ACCESS: if (w_ack) w_next = ST_PUSH;
                    else if (w_timeout) w_next = ST_ABORT;
      ST_PUSH:      if (res_ready) w_next = (r_remaining == 16'd1) ? ST_FIN : ST_WR_SETUP;
      ST_FIN:       w_next = ST_IDLE;
      ST_ABORT:     w_next = ST_IDLE;
      default:      w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      r_state     <= ST_IDLE;
      r_x         <= 32'd0;
      r_remaining <= 16'd0;
      r_settle    <= 8'd0;
      r_err       <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == ST_IDLE && start) begin
        r_x         <= x_start;
        r_remaining <= x_count;
        r_err       <= 1'b0;
      end
      if (r_state == ST_WR_ACCESS && w_ack)
        r_settle <= 8'(SETTLE_CYC - 1);
      else if (r_state == ST_SETTLE && r_settle != 8'd0)
        r_settle <= r_settle - 8'd1;
      if (r_state == ST_PUSH && res_ready) begin
        r_x         <= r_x + 32'd1;
        r_remaining <= r_remaining - 16'd1;
      end
      if (w_timeout)
        r_err <= 1'b1;
    end
  end

  assign busy      = (r_state != ST_IDLE) && (r_state != ST_FIN) && (r_state != ST_ABORT);
  assign done      = (r_state == ST_FIN) || (r_state == ST_ABORT);
  assign err       = r_err;
  assign res_valid = (r_state == ST_PUSH);
  assign res_x     = r_x;
  assign res_data  = w_rdata;

endmodule
